// File: rtl/reg_wb_unit_pkg.sv
// Shared definitions for the register write-back unit.
//  - default data/index widths and queue depth
//  - scope encoding used on res_scope / wr_scope
//  - helper that tells whether a pending write can be forwarded to decode
package reg_wb_unit_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned IDX_W_DEF  = 5;
    localparam int unsigned DEPTH_DEF  = 2;
    localparam int unsigned SCOPE_W    = 2;

    typedef enum logic [SCOPE_W-1:0] {
        SCOPE_NONE = 2'd0,
        SCOPE_BYTE = 2'd1,
        SCOPE_HALF = 2'd2,
        SCOPE_WORD = 2'd3
    } scope_e;

    // Only full-word writes carry the complete register value.
    function automatic logic scope_fwd_ok(input logic [SCOPE_W-1:0] scope);
        return scope == SCOPE_WORD;
    endfunction

endpackage

// File: rtl/reg_wb_unit_fifo.sv
// In-order queue of pending register writes.
//  Ports:
//   clk, rst_n                 clock, async active-low reset
//   push, pop, flush           enqueue input entry / drop head / clear all (flush wins)
//   in_index/in_data/in_scope  entry written on push
//   count                      registered occupancy
//   head_*_c                   oldest entry (valid when count != 0)
//   age_*_c                    every slot in age order, slot 0 oldest, age_valid_c marks occupied
//  Macro REG_WB_FWD_EN: also exposes per-slot data and scope for forwarding.
module reg_wb_unit_fifo
    import reg_wb_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              push,
    input  logic                              pop,
    input  logic                              flush,
    input  logic [IDX_W-1:0]                  in_index,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic [SCOPE_W-1:0]                in_scope,
    output logic [CNT_W-1:0]                  count,
    output logic [IDX_W-1:0]                  head_index_c,
    output logic [DATA_W-1:0]                 head_data_c,
    output logic [SCOPE_W-1:0]                head_scope_c,
    output logic [DEPTH-1:0]                  age_valid_c,
`ifdef REG_WB_FWD_EN
    output logic [DEPTH-1:0][DATA_W-1:0]      age_data_c,
    output logic [DEPTH-1:0][SCOPE_W-1:0]     age_scope_c,
`endif
    output logic [DEPTH-1:0][IDX_W-1:0]       age_index_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [IDX_W-1:0]   mem_index [DEPTH];
    logic [DATA_W-1:0]  mem_data  [DEPTH];
    logic [SCOPE_W-1:0] mem_scope [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: slots are only observed while marked valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_index[wr_ptr] <= in_index;
            mem_data[wr_ptr]  <= in_data;
            mem_scope[wr_ptr] <= in_scope;
        end
    end

    always_comb begin
        head_index_c = mem_index[rd_ptr];
        head_data_c  = mem_data[rd_ptr];
        head_scope_c = mem_scope[rd_ptr];
    end

    // Slots rotated into age order for the forwarding search.
    always_comb begin
        age_valid_c = '0;
        age_index_c = '0;
`ifdef REG_WB_FWD_EN
        age_data_c  = '0;
        age_scope_c = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_valid_c[i] = CNT_W'(i) < count;
            age_index_c[i] = mem_index[rd_ptr + PTR_W'(i)];
`ifdef REG_WB_FWD_EN
            age_data_c[i]  = mem_data[rd_ptr + PTR_W'(i)];
            age_scope_c[i] = mem_scope[rd_ptr + PTR_W'(i)];
`endif
        end
    end

endmodule

// File: rtl/reg_wb_unit.sv
// Write-back requester for reg_file: queues EX/MEM results in order and drives
// one register-file write per cycle, reporting pending writes to decode.
//  Ports:
//   clk, rst_n                         clock, async active-low reset
//   res_valid/res_ready                result handshake (res_ready = queue not full)
//   res_index/res_data/res_scope       result; scope 0 is accepted and dropped
//   flush                              discard queued and staged writes
//   wr_hold                            write port lent elsewhere, hold output stage
//   reg_w_index/wr_data/we/wr_scope    registered reg_file write port
//   pend                               any write queued or staged
//   fwd_index                          operand index read by decode
//   fwd_hit/fwd_data/fwd_busy          combinational forwarding / stall result
//  Macro REG_WB_FWD_EN: word-scope pending writes are forwarded; without it
//  every pending match reports fwd_busy.
module reg_wb_unit
    import reg_wb_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                res_valid,
    output logic                res_ready,
    input  logic [IDX_W-1:0]    res_index,
    input  logic [DATA_W-1:0]   res_data,
    input  logic [SCOPE_W-1:0]  res_scope,
    input  logic                flush,
    input  logic                wr_hold,
    output logic [IDX_W-1:0]    reg_w_index,
    output logic [DATA_W-1:0]   wr_data,
    output logic                we,
    output logic [SCOPE_W-1:0]  wr_scope,
    output logic                pend,
    input  logic [IDX_W-1:0]    fwd_index,
    output logic                fwd_hit,
    output logic [DATA_W-1:0]   fwd_data,
    output logic                fwd_busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]               q_count;
    logic [IDX_W-1:0]               head_index_c;
    logic [DATA_W-1:0]              head_data_c;
    logic [SCOPE_W-1:0]             head_scope_c;
    logic [DEPTH-1:0]               age_valid_c;
    logic [DEPTH-1:0][IDX_W-1:0]    age_index_c;
`ifdef REG_WB_FWD_EN
    logic [DEPTH-1:0][DATA_W-1:0]   age_data_c;
    logic [DEPTH-1:0][SCOPE_W-1:0]  age_scope_c;
`endif

    logic accept_c;
    logic push_any_c;
    logic load_c;
    logic q_empty_c;
    logic bypass_c;
    logic fifo_push_c;
    logic fifo_pop_c;
    logic fwd_found_c;

    // Handshake and stage-load decisions for this cycle.
    always_comb begin
        res_ready   = q_count != CNT_W'(DEPTH);
        pend        = (q_count != '0) | we;
        accept_c    = res_valid && res_ready && !flush;
        push_any_c  = accept_c && (res_scope != SCOPE_NONE);
        load_c      = !we || !wr_hold;
        q_empty_c   = q_count == '0;
        // An empty queue lets a new result go straight into a free output stage.
        bypass_c    = load_c && q_empty_c && push_any_c;
        fifo_push_c = push_any_c && !bypass_c;
        fifo_pop_c  = load_c && !q_empty_c && !flush;
    end

    reg_wb_unit_fifo #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (fifo_push_c),
        .pop          (fifo_pop_c),
        .flush        (flush),
        .in_index     (res_index),
        .in_data      (res_data),
        .in_scope     (res_scope),
        .count        (q_count),
        .head_index_c (head_index_c),
        .head_data_c  (head_data_c),
        .head_scope_c (head_scope_c),
        .age_valid_c  (age_valid_c),
`ifdef REG_WB_FWD_EN
        .age_data_c   (age_data_c),
        .age_scope_c  (age_scope_c),
`endif
        .age_index_c  (age_index_c)
    );

    // Output stage: queue head has priority over a bypassing result to keep order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we          <= 1'b0;
            reg_w_index <= '0;
            wr_data     <= '0;
            wr_scope    <= '0;
        end else if (flush) begin
            we          <= 1'b0;
            reg_w_index <= '0;
            wr_data     <= '0;
            wr_scope    <= '0;
        end else if (load_c) begin
            if (!q_empty_c) begin
                we          <= 1'b1;
                reg_w_index <= head_index_c;
                wr_data     <= head_data_c;
                wr_scope    <= head_scope_c;
            end else if (push_any_c) begin
                we          <= 1'b1;
                reg_w_index <= res_index;
                wr_data     <= res_data;
                wr_scope    <= res_scope;
            end else begin
                we          <= 1'b0;
            end
        end
    end

`ifdef REG_WB_FWD_EN
    // Youngest matching write decides; the output stage is the oldest entry.
    always_comb begin
        fwd_hit     = 1'b0;
        fwd_data    = '0;
        fwd_busy    = 1'b0;
        fwd_found_c = 1'b0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!fwd_found_c && age_valid_c[i] && (age_index_c[i] == fwd_index)) begin
                fwd_found_c = 1'b1;
                if (scope_fwd_ok(age_scope_c[i])) begin
                    fwd_hit  = 1'b1;
                    fwd_data = age_data_c[i];
                end else begin
                    fwd_busy = 1'b1;
                end
            end
        end
        if (!fwd_found_c && we && (reg_w_index == fwd_index)) begin
            fwd_found_c = 1'b1;
            if (scope_fwd_ok(wr_scope)) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data;
            end else begin
                fwd_busy = 1'b1;
            end
        end
    end
`else
    // No forwarding path: any pending write to the operand stalls decode.
    always_comb begin
        fwd_hit     = 1'b0;
        fwd_data    = '0;
        fwd_found_c = we && (reg_w_index == fwd_index);
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (age_valid_c[i] && (age_index_c[i] == fwd_index)) fwd_found_c = 1'b1;
        end
        fwd_busy    = fwd_found_c;
    end
`endif

endmodule

// File: tb/tb_reg_wb_unit.sv
// Self-checking bench for reg_wb_unit: directed scenarios followed by random
// traffic, all checked against an ordered list of pending writes.
module tb_reg_wb_unit;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DEPTH  = 2;

    logic              clk;
    logic              rst_n;
    logic              res_valid;
    logic              res_ready;
    logic [IDX_W-1:0]  res_index;
    logic [DATA_W-1:0] res_data;
    logic [1:0]        res_scope;
    logic              flush;
    logic              wr_hold;
    logic [IDX_W-1:0]  reg_w_index;
    logic [DATA_W-1:0] wr_data;
    logic              we;
    logic [1:0]        wr_scope;
    logic              pend;
    logic [IDX_W-1:0]  fwd_index;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              fwd_busy;

    reg_wb_unit #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_index   (res_index),
        .res_data    (res_data),
        .res_scope   (res_scope),
        .flush       (flush),
        .wr_hold     (wr_hold),
        .reg_w_index (reg_w_index),
        .wr_data     (wr_data),
        .we          (we),
        .wr_scope    (wr_scope),
        .pend        (pend),
        .fwd_index   (fwd_index),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .fwd_busy    (fwd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: every write not yet taken by reg_file, oldest first.
    // Element 0 is what the write port presents whenever the list is non-empty.
    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic [1:0]        scope;
    } ent_t;

    ent_t mq[$];
    int   n_vec;
    int   n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        int queued;
        queued = (mq.size() > 0) ? mq.size() - 1 : 0;
        return queued < int'(DEPTH);
    endfunction

    task automatic check_outputs();
        logic              e_hit;
        logic              e_busy;
        logic [DATA_W-1:0] e_data;
        e_hit  = 1'b0;
        e_busy = 1'b0;
        e_data = '0;
        check("res_ready", 64'(res_ready), 64'(model_ready()));
        check("pend", 64'(pend), 64'(mq.size() != 0));
        check("we", 64'(we), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("wr_index", 64'(reg_w_index), 64'(mq[0].idx));
            check("wr_data", 64'(wr_data), 64'(mq[0].data));
            check("wr_scope", 64'(wr_scope), 64'(mq[0].scope));
        end
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].idx == fwd_index) begin
`ifdef REG_WB_FWD_EN
                if (mq[i].scope == 2'd3) begin
                    e_hit  = 1'b1;
                    e_data = mq[i].data;
                end else begin
                    e_busy = 1'b1;
                end
`else
                e_busy = 1'b1;
`endif
                break;
            end
        end
        check("fwd_hit", 64'(fwd_hit), 64'(e_hit));
        check("fwd_data", 64'(fwd_data), 64'(e_data));
        check("fwd_busy", 64'(fwd_busy), 64'(e_busy));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        logic rdy;
        ent_t e;
        #1;
        check_outputs();
        rdy     = model_ready();
        e.idx   = res_index;
        e.data  = res_data;
        e.scope = res_scope;
        @(posedge clk);
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && !wr_hold) void'(mq.pop_front());
            if (res_valid && rdy && e.scope != 2'd0) mq.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [IDX_W-1:0] idx,
                         input logic [DATA_W-1:0] data, input logic [1:0] scope);
        res_valid = v;
        res_index = idx;
        res_data  = data;
        res_scope = scope;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 2'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        wr_hold   = 1'b0;
        fwd_index = '0;
        idle();
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_we", 64'(we), 64'(0));
        check("rst_index", 64'(reg_w_index), 64'(0));
        check("rst_data", 64'(wr_data), 64'(0));
        check("rst_scope", 64'(wr_scope), 64'(0));
        check("rst_ready", 64'(res_ready), 64'(1));
        check("rst_pend", 64'(pend), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single write: one-cycle we pulse right after acceptance
        drive(1'b1, 5'd3, 32'h0123_0312, 2'd3);
        cycle();
        idle();
        check("t2_we", 64'(we), 64'(1));
        check("t2_index", 64'(reg_w_index), 64'(3));
        check("t2_data", 64'(wr_data), 64'h0123_0312);
        check("t2_scope", 64'(wr_scope), 64'(3));
        cycle();
        check("t2_we_off", 64'(we), 64'(0));

        // Asynchronous reset while a write is staged
        wr_hold = 1'b1;
        drive(1'b1, 5'd4, 32'hdead_beef, 2'd3);
        cycle();
        idle();
        cycle();
        check("t1_we_before", 64'(we), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t1_we", 64'(we), 64'(0));
        check("t1_index", 64'(reg_w_index), 64'(0));
        check("t1_data", 64'(wr_data), 64'(0));
        check("t1_ready", 64'(res_ready), 64'(1));
        check("t1_pend", 64'(pend), 64'(0));
        mq.delete();
        wr_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Held write port fills the queue, release drains in order
        wr_hold = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, IDX_W'(i), 32'h100 + DATA_W'(i), 2'd3);
            cycle();
        end
        idle();
        check("t3_full", 64'(res_ready), 64'(0));
        wr_hold = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("t3_order_we", 64'(we), 64'(1));
            check("t3_order_idx", 64'(reg_w_index), 64'(i));
            cycle();
        end
        check("t3_drained", 64'(we), 64'(0));

        // Scope 0 is accepted but never written
        drive(1'b1, 5'd5, 32'h55, 2'd0);
        cycle();
        idle();
        check("t4_we", 64'(we), 64'(0));
        check("t4_pend", 64'(pend), 64'(0));
        cycle();

        // Flush beats a simultaneous result
        wr_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, IDX_W'(10 + i), DATA_W'(32'h200 + i), 2'd3);
            cycle();
        end
        flush = 1'b1;
        drive(1'b1, 5'd9, 32'h999, 2'd3);
        cycle();
        flush = 1'b0;
        wr_hold = 1'b0;
        idle();
        check("t5_we", 64'(we), 64'(0));
        check("t5_pend", 64'(pend), 64'(0));
        cycle();
        check("t5_no_idx9", 64'(we), 64'(0));

        // Forwarding of a word write, then masked by a younger byte write
        wr_hold   = 1'b1;
        fwd_index = 5'd7;
        drive(1'b1, 5'd7, 32'hA, 2'd3);
        cycle();
        idle();
        #1;
`ifdef REG_WB_FWD_EN
        check("t6_hit_word", 64'(fwd_hit), 64'(1));
        check("t6_data_word", 64'(fwd_data), 64'hA);
        check("t6_busy_word", 64'(fwd_busy), 64'(0));
`else
        check("t6_hit_word", 64'(fwd_hit), 64'(0));
        check("t6_busy_word", 64'(fwd_busy), 64'(1));
`endif
        drive(1'b1, 5'd7, 32'hB, 2'd1);
        cycle();
        idle();
        #1;
        check("t6_hit_byte", 64'(fwd_hit), 64'(0));
        check("t6_busy_byte", 64'(fwd_busy), 64'(1));
        @(negedge clk);
        flush = 1'b1;
        cycle();
        flush   = 1'b0;
        wr_hold = 1'b0;

        // Random traffic against the reference
        for (int n = 0; n < 2000; n++) begin
            drive($urandom_range(0, 3) != 0, IDX_W'($urandom_range(0, 7)),
                  DATA_W'($urandom), 2'($urandom_range(0, 3)));
            flush     = $urandom_range(0, 39) == 0;
            wr_hold   = $urandom_range(0, 2) == 0;
            fwd_index = IDX_W'($urandom_range(0, 7));
            cycle();
        end
        idle();
        flush   = 1'b0;
        wr_hold = 1'b0;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
